// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto a single
// memory port with one outstanding transaction and bounded fetch starvation.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              stray_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    state_t     state, state_next;
    logic [3:0] wait_cnt, wait_cnt_next;
    logic       fetch_win, data_win;

    // Data normally wins; a fetch starved for WAIT_LIMIT data grants takes priority.
    always_comb begin
        fetch_win = 1'b0;
        data_win  = 1'b0;
        if (state == IDLE) begin
            fetch_win = if_req && (!d_req || (wait_cnt == WAIT_LIMIT));
            data_win  = d_req && !fetch_win;
        end
    end

    assign if_gnt = fetch_win;
    assign d_gnt  = data_win;

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            IDLE: begin
                if (fetch_win) begin
                    state_next    = BUSY_IF;
                    wait_cnt_next = 4'd0;
                end else if (data_win) begin
                    state_next = BUSY_D;
                    if (!if_req)
                        wait_cnt_next = 4'd0;
                    else if (wait_cnt != WAIT_LIMIT)
                        wait_cnt_next = wait_cnt + 4'd1;
                end else if (!if_req) begin
                    wait_cnt_next = 4'd0;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ack)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            stray_ack <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                IDLE: begin
                    // An ack with nothing outstanding only flags the error.
                    if (mem_ack)
                        stray_ack <= 1'b1;
                    if (fetch_win) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end else if (data_win) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end
                end
                BUSY_IF: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_done  <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we)
                            d_rdata <= mem_rdata;
                        d_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              if_req, if_gnt, if_done;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req, d_we, d_gnt, d_done;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic              mem_req, mem_we, mem_ack, stray_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stray_ack(stray_ack)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the memory port (0 none, 1 fetch, 2 data) and
    // how many data grants a waiting fetch has already been passed over.
    int          m_owner;
    int          m_wait;
    logic        m_req, m_we, m_ifd, m_dd, m_stray;
    logic [31:0] m_addr, m_wdata, m_ifr, m_dr;
    logic        e_if_gnt, e_d_gnt;
    logic        obs_if_gnt, obs_d_gnt;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_wait = 0;
        m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        m_ifd = 1'b0; m_dd = 1'b0; m_ifr = '0; m_dr = '0; m_stray = 1'b0;
        e_if_gnt = 1'b0; e_d_gnt = 1'b0;
    endtask

    // Called at posedge+1 with inputs already driven; checks at negedge, then
    // advances the model across the next rising edge.
    task automatic cycle();
        @(negedge clk);
        e_if_gnt = (m_owner == 0) && if_req && (!d_req || m_wait == MAX_WAIT);
        e_d_gnt  = (m_owner == 0) && d_req && !e_if_gnt;
        obs_if_gnt = if_gnt;
        obs_d_gnt  = d_gnt;
        check_val("if_gnt",    if_gnt,    e_if_gnt);
        check_val("d_gnt",     d_gnt,     e_d_gnt);
        check_val("mem_req",   mem_req,   m_req);
        check_val("mem_we",    mem_we,    m_we);
        check_val("mem_addr",  mem_addr,  m_addr);
        check_val("mem_wdata", mem_wdata, m_wdata);
        check_val("if_done",   if_done,   m_ifd);
        check_val("d_done",    d_done,    m_dd);
        check_val("if_rdata",  if_rdata,  m_ifr);
        check_val("d_rdata",   d_rdata,   m_dr);
        check_val("stray_ack", stray_ack, m_stray);
        m_ifd = 1'b0;
        m_dd  = 1'b0;
        if (m_owner == 0) begin
            if (mem_ack) m_stray = 1'b1;
            if (e_if_gnt) begin
                m_owner = 1; m_req = 1'b1; m_we = 1'b0; m_addr = if_addr; m_wdata = '0;
                m_wait = 0;
            end else if (e_d_gnt) begin
                m_owner = 2; m_req = 1'b1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                m_wait = if_req ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
            end else if (!if_req) begin
                m_wait = 0;
            end
        end else if (mem_ack) begin
            m_req = 1'b0;
            if (m_owner == 1) begin
                m_ifd = 1'b1; m_ifr = mem_rdata;
            end else begin
                m_dd = 1'b1;
                if (!m_we) m_dr = mem_rdata;
            end
            m_owner = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        if_req = 1'b0; d_req = 1'b0;
        repeat (4) begin
            mem_ack   = (m_owner != 0);
            mem_rdata = $urandom;
            cycle();
        end
        mem_ack = 1'b0;
    endtask

    logic [1:0] exp_order [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                                   2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

    initial begin
        reset_n = 1'b0;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        model_reset();
        #1;
        check_val("rst_mem_req",   mem_req,   1'b0);
        check_val("rst_mem_addr",  mem_addr,  32'h0);
        check_val("rst_stray_ack", stray_ack, 1'b0);
        check_val("rst_d_rdata",   d_rdata,   32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single fetch: grant N, memory request N+1, completion N+2.
        if_req = 1'b1; if_addr = 32'h100;
        cycle();
        check_val("fetch_gnt", obs_if_gnt, 1'b1);
        check_val("fetch_mem_req", mem_req, 1'b1);
        check_val("fetch_mem_addr", mem_addr, 32'h100);
        check_val("fetch_mem_we", mem_we, 1'b0);
        if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h00500093;
        cycle();
        mem_ack = 1'b0;
        check_val("fetch_done", if_done, 1'b1);
        check_val("fetch_rdata", if_rdata, 32'h00500093);
        cycle();
        check_val("fetch_done_pulse", if_done, 1'b0);

        // Held load with a pending fetch; ack withheld ten cycles.
        drain();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        cycle();
        d_req = 1'b0; if_req = 1'b1; if_addr = 32'h88;
        repeat (10) cycle();
        check_val("held_mem_addr", mem_addr, 32'h44);
        check_val("held_no_done", d_done, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        cycle();
        mem_ack = 1'b0;
        check_val("held_d_done", d_done, 1'b1);
        check_val("held_d_rdata", d_rdata, 32'hCAFEF00D);
        cycle();
        check_val("held_then_fetch", obs_if_gnt, 1'b1);

        // Store leaves d_rdata untouched.
        drain();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        cycle();
        d_req = 1'b0;
        check_val("store_mem_we", mem_we, 1'b1);
        check_val("store_mem_addr", mem_addr, 32'h2000);
        check_val("store_mem_wdata", mem_wdata, 32'hDEADBEEF);
        cycle();
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        cycle();
        mem_ack = 1'b0;
        check_val("store_d_done", d_done, 1'b1);
        check_val("store_d_rdata", d_rdata, 32'hCAFEF00D);

        // Contention: both held, ack after two busy cycles.
        drain();
        if_req = 1'b1; if_addr = 32'h400; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check_val($sformatf("contention_%0d", k), {obs_if_gnt, obs_d_gnt}, exp_order[k]);
            cycle();
            mem_ack = 1'b1; mem_rdata = $urandom;
            cycle();
            mem_ack = 1'b0;
        end

        // Reset in the middle of a data transaction.
        drain();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h900;
        cycle();
        d_req = 1'b0; if_req = 1'b1; if_addr = 32'h500;
        cycle();
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_async_mem_req", mem_req, 1'b0);
        check_val("rst_async_d_done", d_done, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check_val("rst_no_d_done", d_done, 1'b0);
        reset_n = 1'b1;
        cycle();
        check_val("rst_first_gnt", obs_if_gnt, 1'b1);

        // Randomized traffic.
        drain();
        for (int i = 0; i < 1500; i++) begin
            if (if_req && e_if_gnt) begin
                if_req = 1'($urandom_range(0, 1)); if_addr = $urandom;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (d_req && e_d_gnt) begin
                d_req = 1'($urandom_range(0, 1)); d_addr = $urandom; d_we = 1'($urandom_range(0, 1));
                d_wdata = $urandom;
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
            end
            mem_ack   = (m_owner != 0) && ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            cycle();
        end

        // Stray acknowledge in IDLE is sticky and touches nothing else.
        drain();
        mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
        cycle();
        mem_ack = 1'b0;
        check_val("stray_set", stray_ack, 1'b1);
        check_val("stray_no_if_done", if_done, 1'b0);
        check_val("stray_no_d_done", d_done, 1'b0);
        cycle();
        cycle();
        check_val("stray_sticky", stray_ack, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
